// File: rtl/weight_pkg.sv
// -----------------------------------------------------------------------------
// weight_pkg
//   Definitions shared by weight_loader and weight_register.
//   - wl_state_e        : loader FSM encoding (IDLE=0, LOAD=1, COMMIT=2)
//   - WEIGHT_TAPS       : default number of weight taps
//   - WEIGHT_DATA_WIDTH : default bits per weight word
// -----------------------------------------------------------------------------
package weight_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } wl_state_e;

  localparam int unsigned WEIGHT_TAPS       = 9;
  localparam int unsigned WEIGHT_DATA_WIDTH = 16;

endpackage

// File: rtl/weight_loader.sv
// -----------------------------------------------------------------------------
// weight_loader
//   Sequences updates of the convolver's N-tap weight_register. Weight words
//   arrive one per cycle on a valid/ready stream (tap 0 first), are assembled
//   into a shadow N*DATA_WIDTH bus, and are committed with a single-cycle
//   write pulse once the convolver is idle.
//
// Parameters
//   N           number of weight taps
//   DATA_WIDTH  bits per weight word
//   CNT_W       tap index counter width
//
// Ports
//   clock         in   rising-edge system clock
//   reset         in   synchronous, active-high
//   load_start    in   pulse: begin a new load sequence (honoured in IDLE only)
//   abort         in   discard the in-progress load (LOAD or COMMIT)
//   w_valid       in   weight word valid
//   w_ready       out  loader accepts a word
//   w_data        in   weight word
//   conv_busy     in   convolver is using the weights; commit is held off
//   write         out  to weight_register.write
//   weight_write  out  to weight_register.weight_write (the shadow bus)
//   loaded        out  a full weight set has been committed since reset
//   done          out  1-cycle pulse coincident with write
//   busy          out  FSM not in IDLE
//
// Build option WEIGHT_LOADER_CKSUM_EN
//   Adds exp_sum (in, DATA_WIDTH) and cksum_err (out). A running modulo
//   2^DATA_WIDTH sum of accepted words is compared against exp_sum in COMMIT;
//   a mismatch suppresses the write, sets the sticky cksum_err and returns to
//   IDLE. cksum_err clears on the next accepted load_start.
// -----------------------------------------------------------------------------
module weight_loader
  import weight_pkg::*;
#(
  parameter int unsigned N          = WEIGHT_TAPS,
  parameter int unsigned DATA_WIDTH = WEIGHT_DATA_WIDTH,
  parameter int unsigned CNT_W      = $clog2(N + 1)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    load_start,
  input  logic                    abort,
  input  logic                    w_valid,
  output logic                    w_ready,
  input  logic [DATA_WIDTH-1:0]   w_data,
  input  logic                    conv_busy,
  output logic                    write,
  output logic [N*DATA_WIDTH-1:0] weight_write,
  output logic                    loaded,
  output logic                    done,
  output logic                    busy
`ifdef WEIGHT_LOADER_CKSUM_EN
  ,
  input  logic [DATA_WIDTH-1:0]   exp_sum,
  output logic                    cksum_err
`endif
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

  wl_state_e               state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [N*DATA_WIDTH-1:0] shadow_q, shadow_d;
  logic                    loaded_q, loaded_d;

  logic start_ok;
  logic hs;
  logic last_hs;
  logic cksum_ok;
  logic cksum_fail;
  logic commit_fire;

  // abort outranks both a same-cycle handshake and a same-cycle commit, so
  // it is folded into every qualifying term rather than only the FSM.
  assign start_ok    = (state_q == IDLE) && load_start && !abort;
  assign hs          = (state_q == LOAD) && w_valid && !abort;
  assign last_hs     = hs && (cnt_q == LAST_IDX);
  assign commit_fire = (state_q == COMMIT) && !abort && !conv_busy && cksum_ok;

`ifdef WEIGHT_LOADER_CKSUM_EN
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic                  cksum_err_q, cksum_err_d;

  // A checksum mismatch is decided as soon as COMMIT is reached; there is no
  // point waiting for conv_busy to drop on a set that will be discarded.
  assign cksum_ok   = (sum_q == exp_sum);
  assign cksum_fail = (state_q == COMMIT) && !abort && !cksum_ok;
  assign cksum_err  = cksum_err_q;

  always_comb begin
    sum_d       = sum_q;
    cksum_err_d = cksum_err_q;
    if (start_ok) begin
      sum_d       = '0;
      cksum_err_d = 1'b0;
    end else begin
      if (hs) begin
        sum_d = sum_q + w_data;
      end
      if (cksum_fail) begin
        cksum_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sum_q       <= '0;
      cksum_err_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      cksum_err_q <= cksum_err_d;
    end
  end
`else
  assign cksum_ok   = 1'b1;
  assign cksum_fail = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
        end else if (last_hs) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        if (abort || commit_fire || cksum_fail) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // Outputs are held low while reset is asserted so that a reset arriving in
  // COMMIT cannot let a write slip out in the cycle before the state clears.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_ready = 1'b0;
    write   = 1'b0;
    done    = 1'b0;
    busy    = 1'b0;
    if (!reset) begin
      busy    = (state_q != IDLE);
      w_ready = (state_q == LOAD) && !abort;
      write   = commit_fire;
      done    = commit_fire;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: tap counter, shadow bus, loaded flag
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    loaded_d = loaded_q || commit_fire;
    if (start_ok) begin
      cnt_d = '0;
    end else if (hs) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (cnt_q == CNT_W'(i)) begin
          shadow_d[i*DATA_WIDTH +: DATA_WIDTH] = w_data;
        end
      end
      // Saturate at the last tap; the FSM leaves LOAD on that handshake.
      if (cnt_q != LAST_IDX) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q    <= '0;
      shadow_q <= '0;
      loaded_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      loaded_q <= loaded_d;
    end
  end

  assign weight_write = shadow_q;
  assign loaded       = loaded_q;

endmodule

// File: tb/tb_weight_loader.sv
// -----------------------------------------------------------------------------
// tb_weight_loader
//   Scoreboard bench for weight_loader (N=9, DATA_WIDTH=16). Each complete
//   load that should commit pushes the expected weight bus; a negedge monitor
//   pops and compares on every write pulse. Inputs change 1 time unit after
//   the rising edge; outputs are sampled between edges.
//   Define WEIGHT_LOADER_CKSUM_EN to also exercise the checksum option.
// -----------------------------------------------------------------------------
module tb_weight_loader;
  import weight_pkg::*;

  localparam int unsigned N  = 9;
  localparam int unsigned DW = 16;
  localparam int unsigned BW = N * DW;

  logic          clock = 1'b0;
  logic          reset;
  logic          load_start;
  logic          abort;
  logic          w_valid;
  logic          w_ready;
  logic [DW-1:0] w_data;
  logic          conv_busy;
  logic          write;
  logic [BW-1:0] weight_write;
  logic          loaded;
  logic          done;
  logic          busy;
`ifdef WEIGHT_LOADER_CKSUM_EN
  logic [DW-1:0] exp_sum;
  logic          cksum_err;
  logic [DW-1:0] tb_sum;
  logic          cksum_corrupt;
  assign exp_sum = tb_sum ^ {{(DW-1){1'b0}}, cksum_corrupt};
`endif

  weight_loader #(.N(N), .DATA_WIDTH(DW), .CNT_W(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .load_start   (load_start),
    .abort        (abort),
    .w_valid      (w_valid),
    .w_ready      (w_ready),
    .w_data       (w_data),
    .conv_busy    (conv_busy),
    .write        (write),
    .weight_write (weight_write),
    .loaded       (loaded),
    .done         (done),
    .busy         (busy)
`ifdef WEIGHT_LOADER_CKSUM_EN
    ,
    .exp_sum      (exp_sum),
    .cksum_err    (cksum_err)
`endif
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int pushes = 0;
  int write_count = 0;
  logic [BW-1:0] sb_q[$];
  logic [BW-1:0] model_ww = '0;

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every write must match the oldest expected set.
  always @(negedge clock) begin : mon
    logic [BW-1:0] exp_v;
    if (write === 1'b1) begin
      write_count++;
      if (sb_q.size() == 0) begin
        check("unexpected_write", BW'(write), '0);
      end else begin
        exp_v = sb_q.pop_front();
        check("commit_ww", weight_write, exp_v);
        check("done_with_write", BW'(done), BW'(1));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic push_exp();
    sb_q.push_back(model_ww);
    pushes++;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    cyc(1);
    load_start = 1'b0;
`ifdef WEIGHT_LOADER_CKSUM_EN
    tb_sum = '0;
`endif
    check("busy_after_start", BW'(busy), BW'(1));
  endtask

  // Offers one word and holds it until accepted (bounded).
  task automatic send_word(input logic [DW-1:0] d, input int idx);
    bit acc = 1'b0;
    w_valid = 1'b1;
    w_data  = d;
    for (int k = 0; k < 50 && !acc; k++) begin
      #1;
      acc = w_ready;
      @(posedge clock);
      #1;
    end
    w_valid = 1'b0;
    if (!acc) begin
      check("hs_timeout", BW'(acc), BW'(1));
    end else begin
      model_ww[idx*DW +: DW] = d;
`ifdef WEIGHT_LOADER_CKSUM_EN
      tb_sum = tb_sum + d;
`endif
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; load_start = 1'b0; abort = 1'b0; w_valid = 1'b0;
    w_data = '0; conv_busy = 1'b0;
`ifdef WEIGHT_LOADER_CKSUM_EN
    tb_sum = '0; cksum_corrupt = 1'b0;
`endif
    cyc(3);
    check("rst_busy", BW'(busy), '0);
    check("rst_ww", weight_write, '0);
    check("rst_loaded", BW'(loaded), '0);
    check("rst_w_ready", BW'(w_ready), '0);
`ifdef WEIGHT_LOADER_CKSUM_EN
    check("rst_cksum_err", BW'(cksum_err), '0);
`endif
    reset = 1'b0;
    cyc(1);

    // Back-to-back load 1..9, convolver idle.
    start_load();
    check("load_w_ready", BW'(w_ready), BW'(1));
    for (int i = 0; i < 9; i++) send_word(DW'(i + 1), i);
    push_exp();
    check("t2_write_latency", BW'(write), BW'(1));
    check("t2_done", BW'(done), BW'(1));
    check("t2_commit_w_ready", BW'(w_ready), '0);
    cyc(1);
    check("t2_ww", weight_write, 144'h0009_0008_0007_0006_0005_0004_0003_0002_0001);
    check("t2_loaded", BW'(loaded), BW'(1));
    check("t2_idle", BW'(busy), '0);
    check("t2_write_once", BW'(write), '0);

    // Reset while in LOAD with cnt=4.
    start_load();
    for (int i = 0; i < 4; i++) send_word(DW'(16'h0E00 + i), i);
    reset = 1'b1;
    #1;
    check("t1_write_in_reset", BW'(write), '0);
    check("t1_ready_in_reset", BW'(w_ready), '0);
    for (int k = 0; k < 5; k++) begin
      cyc(1);
      check("t1_busy", BW'(busy), '0);
      check("t1_ww", weight_write, '0);
      check("t1_loaded", BW'(loaded), '0);
    end
    reset = 1'b0;
    model_ww = '0;
    cyc(2);
    check("t1_idle_after", BW'(busy), '0);

    // Commit held off by conv_busy for 20 cycles.
    conv_busy = 1'b1;
    start_load();
    for (int i = 0; i < 9; i++) send_word(DW'(i + 1), i);
    push_exp();
    for (int k = 0; k < 20; k++) begin
      check("t3_no_write", BW'(write), '0);
      check("t3_w_ready", BW'(w_ready), '0);
      check("t3_ww_stable", weight_write, model_ww);
      cyc(1);
    end
    check("t3_not_loaded", BW'(loaded), '0);
    conv_busy = 1'b0;
    #1;
    check("t3_write_on_release", BW'(write), BW'(1));
    cyc(1);
    check("t3_loaded", BW'(loaded), BW'(1));
    check("t3_idle", BW'(busy), '0);

    // Gapped valid; a stray load_start mid-load must be ignored.
    start_load();
    for (int i = 0; i < 9; i++) begin
      send_word(DW'(32'h1000 + i * 32'h0101), i);
      if (i < 8) begin
        if (i == 3) load_start = 1'b1;
        cyc(1);
        load_start = 1'b0;
      end
    end
    push_exp();
    check("t4_write", BW'(write), BW'(1));
    cyc(1);

    // Abort after 5 words; the aborting cycle also offers a word.
    start_load();
    for (int i = 0; i < 5; i++) send_word(DW'(16'hB000 + i), i);
    abort = 1'b1; w_valid = 1'b1; w_data = 16'hDEAD;
    #1;
    check("t5_ready_during_abort", BW'(w_ready), '0);
    cyc(1);
    abort = 1'b0; w_valid = 1'b0;
    check("t5_idle_after_abort", BW'(busy), '0);
    check("t5_partial_ww", weight_write, model_ww);
    cyc(2);
    check("t5_still_idle", BW'(busy), '0);
    start_load();
    for (int i = 0; i < 9; i++) send_word(DW'(16'hA000 + i), i);
    push_exp();
    check("t5_write", BW'(write), BW'(1));
    cyc(1);

    // Abort in COMMIT outranks a same-cycle release of conv_busy.
    conv_busy = 1'b1;
    start_load();
    for (int i = 0; i < 9; i++) send_word(DW'(16'hC000 + i), i);
    cyc(2);
    abort = 1'b1; conv_busy = 1'b0;
    #1;
    check("abort_commit_no_write", BW'(write), '0);
    cyc(1);
    abort = 1'b0;
    check("abort_commit_idle", BW'(busy), '0);
    cyc(3);

    // load_start together with abort in IDLE; abort alone in IDLE.
    load_start = 1'b1; abort = 1'b1;
    cyc(1);
    load_start = 1'b0;
    check("start_abort_idle", BW'(busy), '0);
    cyc(1);
    abort = 1'b0;
    check("abort_idle_noop", BW'(busy), '0);
    check("abort_idle_ww", weight_write, model_ww);

`ifdef WEIGHT_LOADER_CKSUM_EN
    // exp_sum follows the running sum (45 for 1..9); corrupt bit gives 44.
    start_load();
    for (int i = 0; i < 9; i++) send_word(DW'(i + 1), i);
    push_exp();
    check("t6_sum_ok_write", BW'(write), BW'(1));
    cyc(1);
    check("t6_no_err", BW'(cksum_err), '0);
    cksum_corrupt = 1'b1;
    start_load();
    for (int i = 0; i < 9; i++) send_word(DW'(i + 1), i);
    check("t6_bad_sum_no_write", BW'(write), '0);
    cyc(1);
    check("t6_cksum_err", BW'(cksum_err), BW'(1));
    check("t6_idle", BW'(busy), '0);
    cyc(2);
    check("t6_err_sticky", BW'(cksum_err), BW'(1));
    cksum_corrupt = 1'b0;
    start_load();
    check("t6_err_cleared", BW'(cksum_err), '0);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
`endif

    cyc(3);
    check("sb_empty", BW'(sb_q.size()), '0);
    check("write_count", BW'(write_count), BW'(pushes));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
